// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select, FSM states and load funct3 codes.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitLoad = 2'd1,
    StCommit   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extraction: picks byte/half from an aligned word and sign- or zero-extends it.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'h000000, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'h0000, half_v};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the result, waits for load data, emits a registered commit pulse.
// Optional load watchdog enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RETIRE_W     = 32,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_rd,
  input  logic                in_regwrite,
  input  logic [1:0]          in_wb_sel,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [2:0]          in_funct3,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic [4:0]          write_reg,
  output logic [XLEN-1:0]     write_data,
  output logic                regwrite,
  output logic                busy,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                load_err
);

  wb_state_e state_q, state_d;

  logic                accept;
  logic                load_done;
  logic                tmo;
  logic [XLEN-1:0]     sel_data;
  logic [31:0]         ext_data;

  logic [4:0]          pend_rd_q;
  logic                pend_we_q;
  logic [2:0]          pend_funct3_q;
  logic [1:0]          pend_off_q;

  logic [4:0]          write_reg_q;
  logic [XLEN-1:0]     write_data_q;
  logic                regwrite_q;
  logic [RETIRE_W-1:0] retire_q;

  assign accept    = in_valid && in_ready;
  assign load_done = (state_q == StWaitLoad) && mem_rvalid;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned TmoW = (LOAD_TIMEOUT > 255) ? $clog2(LOAD_TIMEOUT + 1) : 8;

  logic [TmoW-1:0] tmo_cnt_q;
  logic            load_err_q;

  // Counter holds the number of WAIT_LOAD cycles already spent without data.
  assign tmo = (state_q == StWaitLoad) && !mem_rvalid && (tmo_cnt_q == TmoW'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= tmo;
      if (state_q != StWaitLoad) begin
        tmo_cnt_q <= '0;
      end else if (!mem_rvalid) begin
        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      end
    end
  end

  assign load_err = load_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^LOAD_TIMEOUT;
  assign tmo            = 1'b0;
  assign load_err       = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata  (mem_rdata[31:0]),
    .offset (pend_off_q),
    .funct3 (pend_funct3_q),
    .data   (ext_data)
  );

  always_comb begin
    sel_data = in_alu_result;
    unique case (in_wb_sel)
      WB_SEL_ALU:  sel_data = in_alu_result;
      WB_SEL_LINK: sel_data = in_pc + XLEN'(4);
      WB_SEL_IMM:  sel_data = in_imm;
      default:     sel_data = in_alu_result;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (accept) begin
          state_d = (in_wb_sel == WB_SEL_LOAD) ? StWaitLoad : StCommit;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitLoad: begin
        if (load_done || tmo) begin
          state_d = StCommit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q != StWaitLoad);
    busy     = (state_q == StWaitLoad);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_rd_q     <= '0;
      pend_we_q     <= 1'b0;
      pend_funct3_q <= '0;
      pend_off_q    <= '0;
      write_reg_q   <= '0;
      write_data_q  <= '0;
      regwrite_q    <= 1'b0;
      retire_q      <= '0;
    end else begin
      regwrite_q <= 1'b0;
      // Non-loads resolve at accept; loads resolve when the memory answers.
      if (accept && (in_wb_sel != WB_SEL_LOAD)) begin
        write_reg_q  <= in_rd;
        write_data_q <= sel_data;
        regwrite_q   <= in_regwrite && (in_rd != 5'd0);
      end else if (load_done) begin
        write_reg_q  <= pend_rd_q;
        write_data_q <= XLEN'(ext_data);
        regwrite_q   <= pend_we_q && (pend_rd_q != 5'd0);
      end
      if (accept && (in_wb_sel == WB_SEL_LOAD)) begin
        pend_rd_q     <= in_rd;
        pend_we_q     <= in_regwrite;
        pend_funct3_q <= in_funct3;
        pend_off_q    <= in_alu_result[1:0];
      end
      if (state_d == StCommit) begin
        retire_q <= retire_q + RETIRE_W'(1);
      end
    end
  end

  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign regwrite     = regwrite_q;
  assign retire_count = retire_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage directly upstream of the register file write port.
- Accepts one completed instruction per handshake from execute/memory.
- Selects the result source: ALU, load data, link address or immediate. For loads it waits on the data-memory response and extends sub-word data.
- Drives write_reg/write_data/regwrite as a registered, one-cycle commit pulse and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RETIRE_W, 32, width of the retired-instruction counter.
- LOAD_TIMEOUT, 255, cycles allowed in WAIT_LOAD before abort; used only when WB_LOAD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_rd  input  5  destination register
- in_regwrite  input  1  instruction writes rd
- in_wb_sel  input  2  result source: 00 ALU, 01 load, 10 link, 11 immediate
- in_alu_result  input  32  ALU result; also the load address
- in_pc  input  32  instruction PC
- in_imm  input  32  U-type immediate
- in_funct3  input  3  load size/sign
- mem_rvalid  input  1  load data valid
- mem_rdata  input  32  aligned load word
- write_reg  output  5  register file write index
- write_data  output  32  register file write data
- regwrite  output  1  register file write enable, one-cycle pulse
- busy  output  1  high in WAIT_LOAD
- retire_count  output  RETIRE_W  instructions retired
- load_err  output  1  timeout pulse; tied 0 when the feature is off

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - write_reg=0, write_data=0, regwrite=0, retire_count=0, load_err=0
  - any in-flight load is discarded
- States: IDLE, WAIT_LOAD, COMMIT.
- in_ready = 1 in IDLE and COMMIT, 0 in WAIT_LOAD. An accept is in_valid && in_ready on a rising edge.
- On accept, in_rd, in_regwrite, in_wb_sel, in_funct3, in_alu_result[1:0], in_pc and in_imm are captured.
  - wb_sel != 01: next state is COMMIT. regwrite is asserted in the cycle after the accept (latency 1).
  - wb_sel = 01: next state is WAIT_LOAD.
- WAIT_LOAD: stays until mem_rvalid=1. Extended data is then registered and the next state is COMMIT, so regwrite is high the cycle after mem_rvalid.
- mem_rvalid outside WAIT_LOAD is ignored.
- COMMIT:
  - regwrite = captured regwrite && rd != 0
  - retire_count increments by 1, including for rd=0 and no-write instructions, wrapping at 2^RETIRE_W
  - accept in the same cycle goes to COMMIT or WAIT_LOAD; no accept goes to IDLE
  - back-to-back non-load throughput is 1 per cycle
- In every cycle outside COMMIT, regwrite=0; write_reg and write_data hold their last values.
- Link data = in_pc + 4, modulo 2^32 (0xFFFFFFFC gives 0x00000000).
- Load extension:
  - offset = alu_result[1:0]
  - funct3 000 LB: byte[offset], sign-extended
  - funct3 100 LBU: byte[offset], zero-extended
  - funct3 001 LH: half[offset[1]], sign-extended; offset[0] ignored
  - funct3 101 LHU: half[offset[1]], zero-extended
  - funct3 010 and all other codes: full word
- Reset asserted mid-load aborts the load; no write occurs.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - an 8-bit+ cycle counter runs in WAIT_LOAD
  - after LOAD_TIMEOUT cycles without mem_rvalid, the stage goes to COMMIT with regwrite forced 0
  - load_err pulses for one cycle; retire_count still increments
- Undefined: no counter; WAIT_LOAD waits indefinitely; load_err is constant 0.

Decomposition:
- Shared package wb_pkg holds:
  - WB_SEL_ALU/LOAD/LINK/IMM encodings
  - state encodings IDLE/WAIT_LOAD/COMMIT
  - funct3 load constants LB/LH/LW/LBU/LHU
- One combinational sub-module, load_extend, takes (rdata, offset, funct3) and returns the 32-bit extended value.

Test Plan:
- ALU op: accept rd=5, sel=00, alu=0x1234 -> next cycle regwrite=1, write_reg=5, write_data=0x1234, retire_count=1.
- Link wrap: sel=10, pc=0xFFFFFFFC, rd=1 -> write_data=0x00000000, regwrite=1.
- rd=0: sel=11, imm=0xABCD0000 -> regwrite stays 0, retire_count increments.
- Loads, mem_rdata=0x80FF7F01:
  - LB offset 3 -> 0xFFFFFF80
  - LBU offset 1 -> 0x0000007F
  - LH offset 2 -> 0xFFFF80FF
  - LHU offset 0 -> 0x00007F01
  - mem_rvalid delayed 4 cycles -> in_ready=0 and busy=1 for the whole wait.
- Back-to-back: three ALU ops on consecutive cycles -> three consecutive regwrite pulses; reset asserted during WAIT_LOAD -> no write, all outputs 0.
- With WB_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=8, no mem_rvalid -> load_err pulses after 8 cycles, regwrite=0, stage returns to IDLE.
